fc3_fold_ctrl: RTL

FC3_FOLD_CTRL -- requirements
Module: fc3_FoldCtrl

---
 rtl/fc3_pkg.sv | 18 +
 rtl/fc3_CycleCnt.sv | 30 +++
 rtl/fc3_fold_ctrl.sv | 109 ++++++++++
 3 files changed

// File: rtl/fc3_pkg.sv
// Shared types for the fully-connected layer fold controller.
// State encoding plus a helper that sizes the fold index.
package fc3_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CLR  = 3'd1,
    RUN  = 3'd2,
    CAP  = 3'd3,
    DONE = 3'd4
  } fc3_state_t;

  // A single-pass layer still carries a 1-bit fold index.
  function automatic int foldWidth(input int fold);
    return (fold > 1) ? $clog2(fold) : 1;
  endfunction

endpackage

// File: rtl/fc3_CycleCnt.sv
// Bitstream beat counter for one pass: synchronous clear, enable,
// terminal-count flag at BSLEN-1. Saturates at terminal count.
module fc3_CycleCnt #(
  parameter int BSLEN = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic iClr,
  input  logic iEn,
  output logic oTc
);

  localparam int CW = $clog2(BSLEN);
  localparam logic [CW-1:0] LAST = CW'(BSLEN - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (iClr) begin
      cnt <= '0;
    end else if (iEn && !oTc) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign oTc = (cnt == LAST);

endmodule

// File: rtl/fc3_fold_ctrl.sv
// Sequences FOLD time-multiplexed passes of BSLEN bitstream beats over the
// XNOR multiplier array: clear accumulators, accumulate, capture per pass.
module fc3_fold_ctrl
  import fc3_pkg::*;
#(
  parameter int IDIM  = 1,
  parameter int FOLD  = 1,
  parameter int ODIM  = 1,
  parameter int BSLEN = 256
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       iStart,
  input  logic                       iAbort,
  input  logic                       iValid,
  output logic                       oBusy,
  output logic [foldWidth(FOLD)-1:0] oFold,
  output logic                       oMulEn,
  output logic                       oAccClr,
  output logic                       oCap,
  output logic                       oDone
);

  localparam int FW = foldWidth(FOLD);
  localparam logic [FW-1:0] FOLD_LAST = FW'(FOLD - 1);

  if (IDIM < 1 || FOLD < 1 || BSLEN < 2 || (ODIM % FOLD) != 0) begin : gBadParam
    $error("fc3_fold_ctrl: illegal parameters IDIM=%0d FOLD=%0d ODIM=%0d BSLEN=%0d",
           IDIM, FOLD, ODIM, BSLEN);
  end

  fc3_state_t    state, stateNext;
  logic [FW-1:0] fold, foldNext;
  logic          cntClr, cntEn, cntTc;

  fc3_CycleCnt #(
    .BSLEN(BSLEN)
  ) uCycleCnt (
    .clk  (clk),
    .rst_n(rst_n),
    .iClr (cntClr),
    .iEn  (cntEn),
    .oTc  (cntTc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      fold  <= '0;
    end else begin
      state <= stateNext;
      fold  <= foldNext;
    end
  end

  // Abort wins over every transition and leaves the counter cleared.
  always_comb begin
    stateNext = state;
    foldNext  = fold;
    cntClr    = 1'b0;
    cntEn     = 1'b0;
    if (state != IDLE && iAbort) begin
      stateNext = IDLE;
      foldNext  = '0;
      cntClr    = 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (iStart) begin
            stateNext = CLR;
            foldNext  = '0;
          end
        end
        CLR: begin
          cntClr    = 1'b1;
          stateNext = RUN;
        end
        RUN: begin
          cntEn = iValid;
          if (iValid && cntTc) stateNext = CAP;
        end
        CAP: begin
          if (fold < FOLD_LAST) begin
            stateNext = CLR;
            foldNext  = fold + FW'(1);
          end else begin
            stateNext = DONE;
          end
        end
        DONE: begin
          stateNext = IDLE;
          foldNext  = '0;
        end
        default: begin
          stateNext = IDLE;
          foldNext  = '0;
        end
      endcase
    end
  end

  assign oBusy   = (state != IDLE);
  assign oFold   = fold;
  assign oMulEn  = (state == RUN) && iValid;
  assign oAccClr = (state == CLR);
  assign oCap    = (state == CAP);
  assign oDone   = (state == DONE);

endmodule
